// File: rtl/modular_multiplier_interleaved.sv
// Interleaved shift-add modular multiplier: y = (a * b) mod Q.
// One multiplier bit is consumed per cycle, MSB first. The accumulator is
// reduced after every doubling and after every addition, so it stays below Q
// and no double-width product is ever formed.
module modular_multiplier_interleaved #(
    parameter int Q  = 12289,
    parameter int K  = $clog2(Q),
    parameter int CW = $clog2(K) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] y
);

    localparam logic [K:0]    Q_EXT     = Q[K:0];
    localparam logic [K-1:0]  Q_K       = Q[K-1:0];
    localparam logic [CW-1:0] CNT_START = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [K-1:0]  acc_q, acc_d;
    logic [K-1:0]  a_r_q, a_r_d;
    logic [K-1:0]  b_r_q, b_r_d;
    logic [K-1:0]  y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [K-1:0]  a_red, b_red;
    logic [K:0]    dbl;
    logic [K-1:0]  t1;
    logic [K:0]    t2_sum;
    logic [K-1:0]  t2;
    logic          bit_sel;

    // Operand pre-reduction and one shift-add-reduce step; 2^K < 2Q, so a single
    // conditional subtract brings every intermediate back below Q.
    always_comb begin
        a_red   = ({1'b0, a} >= Q_EXT) ? (a - Q_K) : a;
        b_red   = ({1'b0, b} >= Q_EXT) ? (b - Q_K) : b;
        dbl     = {acc_q, 1'b0};
        t1      = (dbl >= Q_EXT) ? (dbl[K-1:0] - Q_K) : dbl[K-1:0];
        bit_sel = b_r_q[cnt_q[CW-2:0]];
        t2_sum  = {1'b0, t1} + (bit_sel ? {1'b0, a_r_q} : '0);
        t2      = (t2_sum >= Q_EXT) ? (t2_sum[K-1:0] - Q_K) : t2_sum[K-1:0];
    end

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_r_d   = a_r_q;
        b_r_d   = b_r_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_r_d   = a_red;
                    b_r_d   = b_red;
                    acc_d   = '0;
                    cnt_d   = CNT_START;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = t2;
                if (cnt_q == '0) begin
                    y_d     = t2;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            a_r_q       <= '0;
            b_r_q       <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_r_q       <= a_r_d;
            b_r_q       <= b_r_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule
